// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte-addressed load/store controller with RMW sub-word stores and extended sub-word loads
module lsu_ctrl #(
  parameter int DEPTH = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WRITE = 3'd2, RMW_RD = 3'd3, RMW_WR = 3'd4;
  logic [2:0]  state;
  logic [1:0]  sz_q;
  logic        u_q, bad;
  logic [31:0] a_q, wd_q, merge, mask, lane, ld;
  logic [4:0]  sh;
  always_comb begin
    bad = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
          {2'b00, addr[31:2]} >= 32'(DEPTH);
    sh = {a_q[1:0], 3'b000};
    mask = (sz_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    lane = mem_rdata >> sh;
    ld = sz_q == 2'b00 ? {{24{lane[7] & ~u_q}}, lane[7:0]} :
         sz_q == 2'b01 ? {{16{lane[15] & ~u_q}}, lane[15:0]} : mem_rdata;
  end
  assign ready     = state == IDLE;
  assign mem_we    = state == WRITE || state == RMW_WR;
  assign mem_addr  = {2'b00, a_q[31:2]};
  assign mem_wdata = state == RMW_WR ? merge : wd_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      a_q   <= '0;
      wd_q  <= '0;
      sz_q  <= '0;
      u_q   <= 1'b0;
      merge <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          a_q  <= addr;
          wd_q <= wdata;
          sz_q <= size;
          u_q  <= uns;
          if (bad) {done, err} <= 2'b11;
          else state <= !is_store ? LOAD : size == 2'b10 ? WRITE : RMW_RD;
        end
        LOAD: begin
          rdata <= ld;
          done  <= 1'b1;
          state <= IDLE;
        end
        RMW_RD: begin
          merge <= (mem_rdata & ~mask) | ((wd_q << sh) & mask);
          state <= RMW_WR;
        end
        WRITE, RMW_WR: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the single-cycle datapath and the word-organised data memory. It accepts one byte-addressed load or store request at a time, checks alignment and range, and issues word accesses. Sub-word stores (SB/SH) use a read-modify-write. Sub-word loads are returned sign- or zero-extended in a registered result.

## Interface
- DEPTH, 100: number of 32-bit words in the attached data memory; valid word index is 0..DEPTH-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request strobe; sampled only when ready=1.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; byte in [7:0], half in [15:0].
- ready  out  1  high in IDLE; request accepted at a clock edge where req and ready are both 1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request rejected, no memory access made.
- rdata  out  32  registered load result; holds until the next load completes.
- mem_addr  out  32  word index to memory, equal to the captured addr[31:2].
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable, active-high; memory writes on the rising clk edge.
- mem_rdata  in  32  asynchronous memory read data for mem_addr.

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR. ready = (state==IDLE).
- On accept, capture is_store, size, uns, addr and wdata into registers.
- Reject on any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= DEPTH.
  - On reject, stay in IDLE and assert done=1, err=1 in the next cycle. No memory access is made.
- Valid load: go to LOAD.
  - In LOAD, select the lane from mem_rdata (little-endian: byte lane addr[1:0], half lane addr[1]) and extend per uns.
  - Register the result into rdata at the end of LOAD, then return to IDLE.
- Valid SW: go to WRITE. mem_we=1 and mem_wdata=captured wdata, then return to IDLE.
- Valid SB/SH: go to RMW_RD, then RMW_WR, then IDLE.
  - RMW_RD: mem_we=0. At the edge, merge register <= mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR: mem_we=1 and mem_wdata=merge register.
- done=1, err=0 is asserted in the cycle after the final access state.
- req while ready=0 is ignored, not queued.
- mem_we is 1 only in WRITE and RMW_WR; it is decoded from state.
- mem_wdata = merge register in RMW_WR; otherwise it is the captured wdata.

## Timing
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
- Request accepted at edge E0:
  - Reject: done and err are high in the cycle after E0.
  - LW/LH/LB/SW: one access cycle, done high after E1.
  - SH/SB: two access cycles, done high after E2.
- done, err and ready are all high in the same cycle after completion. A new request is accepted at that cycle's edge, giving back-to-back throughput.
- err is cleared together with done on the next edge.
- Reset asserted mid-operation: return to IDLE immediately. mem_we drops asynchronously, so there is no partial or late write. rdata is cleared.
- rdata changes only at the completion edge of a valid load. Stores and rejected requests leave rdata unchanged.

## Test plan
- Word store then load: SW 0xDEADBEEF to addr 0x8, then LW 0x8. Required: done after 1 access cycle; rdata=0xDEADBEEF; mem_we high for exactly one cycle.
- Sub-word store: memory word 2 = 0x11223344. SB wdata=0xAA at addr 0x9, then LW 0x8. Required: two-cycle RMW; word becomes 0x1122AA44. Then SH wdata=0x5566 at 0xA; word becomes 0x5566AA44.
- Extension: word 2 = 0x80FF7F80. Required results:
  - LB 0x8 -> 0xFFFFFF80; LBU 0x8 -> 0x00000080.
  - LH 0xA -> 0xFFFF80FF; LHU 0xA -> 0x000080FF.
- Rejects: each of the following gives done=1, err=1 one cycle after accept, mem_we never asserted, rdata unchanged.
  - LH 0x3.
  - SW 0x6.
  - size=11.
  - LW 0x190 (index 100, DEPTH=100).
- Busy and back-to-back: hold req high through an SB. Required: req ignored during RMW_RD and RMW_WR; next request accepted in the done cycle; no lost or duplicated done pulses.
- Reset mid-RMW: drop rst during RMW_RD. Required: state IDLE, mem_we=0, target word unchanged, ready=1 after release.
